// File: rtl/morra_pkg.sv
// Shared types and the move-dominance rule for the parametrised morra cinese referee.
package morra_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        SASSO   = 2'b01,
        CARTA   = 2'b10,
        FORBICE = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        INVAL = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10,
        DRAW  = 2'b11
    } manche_t;

    typedef enum logic [1:0] {
        ONGOING = 2'b00,
        WIN1    = 2'b01,
        WIN2    = 2'b10,
        TIE     = 2'b11
    } partita_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    // carta > sasso, sasso > forbice, forbice > carta
    function automatic logic beats(input move_t a, input move_t b);
        return ((a == CARTA)   && (b == SASSO))   ||
               ((a == SASSO)   && (b == FORBICE)) ||
               ((a == FORBICE) && (b == CARTA));
    endfunction

endpackage

// File: rtl/morra_judge.sv
// Combinational judge for one manche, including the optional repeat-ban on the last winner.
module morra_judge
    import morra_pkg::*;
#(
    parameter bit BAN_REPEAT = 1'b1
) (
    input  move_t   i_p1,
    input  move_t   i_p2,
    input  logic    i_ban_valid,
    input  logic    i_ban_player,
    input  move_t   i_ban_move,
    output manche_t o_manche
);

    logic w_banned;

    // ban_player 0 refers to player 1, 1 to player 2
    assign w_banned = BAN_REPEAT && i_ban_valid &&
                      (i_ban_player ? (i_p2 == i_ban_move) : (i_p1 == i_ban_move));

    // Classify the move pair into invalid, draw or a winner
    always_comb begin
        o_manche = INVAL;
        if ((i_p1 == NONE) || (i_p2 == NONE) || w_banned) begin
            o_manche = INVAL;
        end else if (i_p1 == i_p2) begin
            o_manche = DRAW;
        end else if (beats(i_p1, i_p2)) begin
            o_manche = P1;
        end else begin
            o_manche = P2;
        end
    end

endmodule

// File: rtl/morra_cinese_param.sv
// Match referee: FSM, score/manche counters, repeat-ban register and end-of-match decision.
module morra_cinese_param
    import morra_pkg::*;
#(
    parameter int MIN_ROUNDS = 4,
    parameter int MARGIN     = 2,
    parameter int SCORE_W    = 5,
    parameter bit BAN_REPEAT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         PRIMO,
    input  logic [1:0]         SECONDO,
    input  logic               INIZIA,
    output logic [1:0]         MANCHE,
    output logic [1:0]         PARTITA,
    output logic [SCORE_W-1:0] SCORE_P1,
    output logic [SCORE_W-1:0] SCORE_P2
);

    // The longest match (MIN_ROUNDS + 15) must fit in the counters so nothing can wrap
    generate
        if ((2**SCORE_W) - 1 < MIN_ROUNDS + 15) begin : g_width_check
            $error("SCORE_W too small for MIN_ROUNDS + 15 manches");
        end
    endgenerate

    localparam logic [SCORE_W-1:0] MIN_R    = SCORE_W'(MIN_ROUNDS);
    localparam logic [SCORE_W:0]   MARGIN_W = (SCORE_W+1)'(MARGIN);

    state_t             r_state,      w_state_nx;
    logic [SCORE_W-1:0] r_max,        w_max_nx;
    logic [SCORE_W-1:0] r_s1,         w_s1_nx;
    logic [SCORE_W-1:0] r_s2,         w_s2_nx;
    logic [SCORE_W-1:0] r_played,     w_played_nx;
    logic               r_ban_valid,  w_ban_valid_nx;
    logic               r_ban_player, w_ban_player_nx;
    move_t              r_ban_move,   w_ban_move_nx;
    manche_t            r_manche,     w_manche_nx;
    partita_t           r_partita,    w_partita_nx;

    manche_t            w_judge;
    logic [SCORE_W-1:0] w_s1_inc;
    logic [SCORE_W-1:0] w_s2_inc;
    logic [SCORE_W-1:0] w_played_inc;
    logic signed [SCORE_W:0] w_diff;
    logic [SCORE_W:0]   w_abs;
    logic               w_margin_hit;
    logic               w_max_hit;
    partita_t           w_lead;

    morra_judge #(
        .BAN_REPEAT (BAN_REPEAT)
    ) u_judge (
        .i_p1         (move_t'(PRIMO)),
        .i_p2         (move_t'(SECONDO)),
        .i_ban_valid  (r_ban_valid),
        .i_ban_player (r_ban_player),
        .i_ban_move   (r_ban_move),
        .o_manche     (w_judge)
    );

    // Post-update counters, so the end check sees this manche's result
    assign w_s1_inc     = r_s1 + {{(SCORE_W-1){1'b0}}, (w_judge == P1)};
    assign w_s2_inc     = r_s2 + {{(SCORE_W-1){1'b0}}, (w_judge == P2)};
    assign w_played_inc = r_played + {{(SCORE_W-1){1'b0}}, 1'b1};
    assign w_diff       = $signed({1'b0, w_s1_inc}) - $signed({1'b0, w_s2_inc});
    assign w_abs        = w_diff[SCORE_W] ? (-w_diff) : w_diff;
    assign w_margin_hit = (w_played_inc >= MIN_R) && (w_abs >= MARGIN_W);
    assign w_max_hit    = (w_played_inc == r_max);
    assign w_lead       = (w_s1_inc > w_s2_inc) ? WIN1 :
                          ((w_s2_inc > w_s1_inc) ? WIN2 : TIE);

    // Next-state and next-output logic
    always_comb begin
        w_state_nx      = r_state;
        w_max_nx        = r_max;
        w_s1_nx         = r_s1;
        w_s2_nx         = r_s2;
        w_played_nx     = r_played;
        w_ban_valid_nx  = r_ban_valid;
        w_ban_player_nx = r_ban_player;
        w_ban_move_nx   = r_ban_move;
        w_manche_nx     = INVAL;
        w_partita_nx    = r_partita;

        if (INIZIA) begin
            w_max_nx       = MIN_R + SCORE_W'({PRIMO, SECONDO});
            w_s1_nx        = {SCORE_W{1'b0}};
            w_s2_nx        = {SCORE_W{1'b0}};
            w_played_nx    = {SCORE_W{1'b0}};
            w_ban_valid_nx = 1'b0;
            w_partita_nx   = ONGOING;
            w_state_nx     = PLAY;
        end else begin
            case (r_state)
                PLAY: begin
                    if (w_judge != INVAL) begin
                        w_s1_nx     = w_s1_inc;
                        w_s2_nx     = w_s2_inc;
                        w_played_nx = w_played_inc;
                        w_manche_nx = w_judge;
                        if (w_judge == DRAW) begin
                            w_ban_valid_nx = 1'b0;
                        end else begin
                            w_ban_valid_nx  = 1'b1;
                            w_ban_player_nx = (w_judge == P2);
                            w_ban_move_nx   = (w_judge == P2) ? move_t'(SECONDO) : move_t'(PRIMO);
                        end
                        if (w_margin_hit || w_max_hit) begin
                            w_partita_nx = w_lead;
                            w_state_nx   = DONE;
                        end else begin
                            w_partita_nx = ONGOING;
                        end
                    end else begin
                        w_manche_nx = INVAL;
                    end
                end
                IDLE, DONE: begin
                    w_manche_nx = INVAL;
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_max        <= MIN_R;
            r_s1         <= {SCORE_W{1'b0}};
            r_s2         <= {SCORE_W{1'b0}};
            r_played     <= {SCORE_W{1'b0}};
            r_ban_valid  <= 1'b0;
            r_ban_player <= 1'b0;
            r_ban_move   <= NONE;
            r_manche     <= INVAL;
            r_partita    <= ONGOING;
        end else begin
            r_state      <= w_state_nx;
            r_max        <= w_max_nx;
            r_s1         <= w_s1_nx;
            r_s2         <= w_s2_nx;
            r_played     <= w_played_nx;
            r_ban_valid  <= w_ban_valid_nx;
            r_ban_player <= w_ban_player_nx;
            r_ban_move   <= w_ban_move_nx;
            r_manche     <= w_manche_nx;
            r_partita    <= w_partita_nx;
        end
    end

    assign MANCHE   = r_manche;
    assign PARTITA  = r_partita;
    assign SCORE_P1 = r_s1;
    assign SCORE_P2 = r_s2;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Bench for morra_cinese_param: one instance with the repeat-ban, one without, both checked against a rule-level model.
module tb_morra_cinese_param;

    localparam int MINR = 4;
    localparam int MRG  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] primo, secondo;
    logic       inizia;
    logic [1:0] man_a, par_a, man_b, par_b;
    logic [4:0] s1_a, s2_a, s1_b, s2_b;
    logic [13:0] obs [2];

    int checks   = 0;
    int failures = 0;

    // Reference model state, one slot per instance (0: ban on, 1: ban off)
    int m_phase [2];   // 0 idle, 1 playing, 2 finished
    int m_s1 [2], m_s2 [2], m_played [2], m_max [2];
    int m_lastw [2], m_lastmv [2], m_man [2], m_par [2];

    always #5 clk = ~clk;

    morra_cinese_param #(.MIN_ROUNDS(4), .MARGIN(2), .SCORE_W(5), .BAN_REPEAT(1'b1)) u_dut_ban (
        .clk(clk), .rst_n(rst_n), .PRIMO(primo), .SECONDO(secondo), .INIZIA(inizia),
        .MANCHE(man_a), .PARTITA(par_a), .SCORE_P1(s1_a), .SCORE_P2(s2_a)
    );

    morra_cinese_param #(.MIN_ROUNDS(4), .MARGIN(2), .SCORE_W(5), .BAN_REPEAT(1'b0)) u_dut_noban (
        .clk(clk), .rst_n(rst_n), .PRIMO(primo), .SECONDO(secondo), .INIZIA(inizia),
        .MANCHE(man_b), .PARTITA(par_b), .SCORE_P1(s1_b), .SCORE_P2(s2_b)
    );

    assign obs[0] = {man_a, par_a, s1_a, s2_a};
    assign obs[1] = {man_b, par_b, s1_b, s2_b};

    // Rule-level model: moves 1..3 with a beating b when (a - b) mod 3 == 1
    task automatic model_step(input int d, input bit ban);
        int  p1, p2, diff;
        bit  valid;
        p1 = int'(primo);
        p2 = int'(secondo);
        if (!rst_n) begin
            m_phase[d] = 0; m_s1[d] = 0; m_s2[d] = 0; m_played[d] = 0;
            m_lastw[d] = 0; m_man[d] = 0; m_par[d] = 0;
        end else if (inizia) begin
            m_max[d] = MINR + p1 * 4 + p2;
            m_s1[d] = 0; m_s2[d] = 0; m_played[d] = 0; m_lastw[d] = 0;
            m_man[d] = 0; m_par[d] = 0; m_phase[d] = 1;
        end else if (m_phase[d] != 1) begin
            m_man[d] = 0;
        end else begin
            valid = (p1 != 0) && (p2 != 0);
            if (ban && m_lastw[d] == 1 && p1 == m_lastmv[d]) valid = 1'b0;
            if (ban && m_lastw[d] == 2 && p2 == m_lastmv[d]) valid = 1'b0;
            if (!valid) begin
                m_man[d] = 0;
            end else begin
                m_played[d]++;
                if (p1 == p2) begin
                    m_man[d] = 3; m_lastw[d] = 0;
                end else if ((p1 - p2 + 3) % 3 == 1) begin
                    m_man[d] = 1; m_s1[d]++; m_lastw[d] = 1; m_lastmv[d] = p1;
                end else begin
                    m_man[d] = 2; m_s2[d]++; m_lastw[d] = 2; m_lastmv[d] = p2;
                end
                diff = m_s1[d] - m_s2[d];
                if (diff < 0) diff = -diff;
                if (m_played[d] >= MINR && diff >= MRG) begin
                    m_par[d] = (m_s1[d] > m_s2[d]) ? 1 : 2;
                    m_phase[d] = 2;
                end else if (m_played[d] == m_max[d]) begin
                    m_par[d] = (m_s1[d] > m_s2[d]) ? 1 : ((m_s2[d] > m_s1[d]) ? 2 : 3);
                    m_phase[d] = 2;
                end
            end
        end
    endtask

    function automatic logic [13:0] exp_of(input int d);
        return {2'(m_man[d]), 2'(m_par[d]), 5'(m_s1[d]), 5'(m_s2[d])};
    endfunction

    task automatic cycle(input logic r, input logic [1:0] p1, input logic [1:0] p2, input logic ini);
        rst_n = r; primo = p1; secondo = p2; inizia = ini;
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 2'b00, 2'b00, 1'b1);
        cycle(1'b0, 2'b00, 2'b00, 1'b1);
        checks++;
        if (obs[0] !== 14'h0000) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", obs[0], 14'h0000);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 2'b01, 2'b11, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_of(d)) begin
                    failures++; $display("FAIL idle_ignore[%0d] dut%0d got=%h exp=%h", i, d, obs[d], exp_of(d));
                end
            end
        end
    endtask

    task automatic test_p1_sweep();
        logic [1:0] p1s [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        logic [1:0] p2s [5] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01};
        cycle(1'b1, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, p1s[i], p2s[i], 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_of(d)) begin
                    failures++; $display("FAIL p1_sweep[%0d] dut%0d got=%h exp=%h", i, d, obs[d], exp_of(d));
                end
            end
            if (i == 3) begin
                checks++;
                if ({man_a, par_a, s1_a} !== {2'b01, 2'b01, 5'd4}) begin
                    failures++; $display("FAIL p1_margin_win got=%b/%b/%0d exp=01/01/4", man_a, par_a, s1_a);
                end
            end
        end
        checks++;
        if ({man_a, par_a} !== 4'b0001) begin
            failures++; $display("FAIL done_hold got=%b/%b exp=00/01", man_a, par_a);
        end
    endtask

    task automatic test_ban();
        logic [1:0] p1s [3] = '{2'b01, 2'b01, 2'b10};
        logic [1:0] p2s [3] = '{2'b11, 2'b10, 2'b11};
        cycle(1'b1, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, p1s[i], p2s[i], 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_of(d)) begin
                    failures++; $display("FAIL ban[%0d] dut%0d got=%h exp=%h", i, d, obs[d], exp_of(d));
                end
            end
            if (i == 1) begin
                checks++;
                if ({man_a, s1_a, s2_a, man_b} !== {2'b00, 5'd1, 5'd0, 2'b10}) begin
                    failures++; $display("FAIL ban_block got=%b/%0d/%0d noban=%b exp=00/1/0 noban=10", man_a, s1_a, s2_a, man_b);
                end
            end
        end
        checks++;
        if ({man_a, s1_a, s2_a} !== {2'b10, 5'd1, 5'd1}) begin
            failures++; $display("FAIL ban_after got=%b/%0d/%0d exp=10/1/1", man_a, s1_a, s2_a);
        end
    endtask

    task automatic test_tie_max();
        cycle(1'b1, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'b01, 2'b01, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_of(d)) begin
                    failures++; $display("FAIL tie_max[%0d] dut%0d got=%h exp=%h", i, d, obs[d], exp_of(d));
                end
            end
            checks++;
            if ({man_a, par_a} !== {2'b11, (i == 3) ? 2'b11 : 2'b00}) begin
                failures++; $display("FAIL tie_partita[%0d] got=%b/%b", i, man_a, par_a);
            end
        end
    endtask

    task automatic test_restart();
        cycle(1'b1, 2'b00, 2'b00, 1'b1);
        cycle(1'b1, 2'b01, 2'b11, 1'b0);
        cycle(1'b1, 2'b10, 2'b01, 1'b0);
        cycle(1'b1, 2'b01, 2'b10, 1'b1);
        checks++;
        if (obs[0] !== 14'h0000) begin
            failures++; $display("FAIL restart_clear got=%h exp=%h", obs[0], 14'h0000);
        end
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) cycle(1'b1, 2'b01, 2'b11, 1'b0);
            else            cycle(1'b1, 2'b11, 2'b01, 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_of(d)) begin
                    failures++; $display("FAIL restart[%0d] dut%0d got=%h exp=%h", i, d, obs[d], exp_of(d));
                end
            end
        end
        checks++;
        if ({par_a, s1_a, s2_a} !== {2'b11, 5'd5, 5'd5}) begin
            failures++; $display("FAIL restart_tie got=%b/%0d/%0d exp=11/5/5", par_a, s1_a, s2_a);
        end
    endtask

    task automatic test_invalid();
        logic [1:0] p1s [4] = '{2'b01, 2'b00, 2'b10, 2'b01};
        logic [1:0] p2s [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
        cycle(1'b1, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, p1s[i], p2s[i], 1'b0);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_of(d)) begin
                    failures++; $display("FAIL invalid[%0d] dut%0d got=%h exp=%h", i, d, obs[d], exp_of(d));
                end
            end
        end
        checks++;
        if ({man_a, man_b} !== 4'b0010) begin
            failures++; $display("FAIL invalid_ban_kept got=%b/%b exp=00/10", man_a, man_b);
        end
    endtask

    task automatic test_random();
        logic       r, ini;
        logic [1:0] p1, p2;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            ini = ($urandom_range(0, 29) == 0);
            p1  = 2'($urandom_range(0, 3));
            p2  = 2'($urandom_range(0, 3));
            cycle(r, p1, p2, ini);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_of(d)) begin
                    failures++; $display("FAIL random[%0d] dut%0d got=%h exp=%h", i, d, obs[d], exp_of(d));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; primo = 2'b00; secondo = 2'b00; inizia = 1'b0;
        test_reset();
        test_p1_sweep();
        test_ban();
        test_tie_max();
        test_restart();
        test_invalid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
